modn_updn_counter: RTL and testbench
====================================

MODN_UPDN_COUNTER -- requirements
Module: modn_updn_counter

Interface
REQ-001 Parameter MODULUS, default 12: count range 0..MODULUS-1; legal range 2..65536.
REQ-002 Parameter WIDTH, default $clog2(MODULUS) (4 at default): width of data_in/count_out.
REQ-003 Parameter RESET_VAL, default 0: count value after reset; must be < MODULUS.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable; 1 = advance one step per clock.
REQ-007 load  input  1  synchronous load request.
REQ-008 mode  input  1  direction; 1 = up, 0 = down.
REQ-009 wrap_en  input  1  boundary policy; 1 = wrap modulo MODULUS, 0 = saturate.
REQ-010 data_in  input  WIDTH  load value.
REQ-011 count_out  output  WIDTH  registered count.
REQ-012 tc  output  1  terminal count, combinational from count_out and mode.
REQ-013 carry_out  output  1  registered one-cycle pulse on up-wrap.
REQ-014 borrow_out  output  1  registered one-cycle pulse on down-wrap.
REQ-015 load_err  output  1  registered one-cycle pulse on out-of-range load.

Function
REQ-016 Priority per clock edge: load > en > hold.
REQ-017 load=1, data_in < MODULUS: count_out <= data_in next edge; en ignored that cycle.
REQ-018 load=1, data_in >= MODULUS: count_out <= MODULUS-1; load_err=1 for one cycle.
REQ-019 load=0, en=1, mode=1, count_out < MODULUS-1: count_out <= count_out+1.
REQ-020 load=0, en=1, mode=0, count_out > 0: count_out <= count_out-1.
REQ-021 Up at MODULUS-1, wrap_en=1: count_out <= 0; carry_out=1 for one cycle.
REQ-022 Down at 0, wrap_en=1: count_out <= MODULUS-1; borrow_out=1 for one cycle.
REQ-023 Up at MODULUS-1 or down at 0 with wrap_en=0: count_out holds; no carry/borrow pulse.
REQ-024 en=0 and load=0: count_out holds; carry_out, borrow_out, load_err = 0.
REQ-025 tc = 1 when (mode=1 and count_out=MODULUS-1) or (mode=0 and count_out=0); else 0.
REQ-026 Latency: one clock from input sample to count_out change; pulses coincide with new count value.
REQ-027 mode or wrap_en change takes effect on the same edge where sampled; no pipeline.
REQ-028 carry_out, borrow_out, load_err are mutually exclusive in any cycle.
REQ-029 count_out never holds a value >= MODULUS.
REQ-030 Next-count arithmetic uses WIDTH+1 bits internally; no silent overflow when MODULUS = 2**WIDTH.

Reset
REQ-031 reset_n=0 asynchronously forces count_out=RESET_VAL and carry_out=borrow_out=load_err=0.
REQ-032 Reset asserted mid-count overrides load and en immediately; no pulse issued.
REQ-033 First count/load action occurs on the first rising clock edge after reset_n deasserts.

Structure
REQ-034 Shared package modn_pkg holds the direction constants (DIR_UP=1, DIR_DN=0) and the policy constants (POL_WRAP=1, POL_SAT=0).
REQ-035 Combinational next-state logic lives in sub-module modn_next: inputs count, load, en, mode, wrap_en, data_in; outputs next count and the three event flags.
REQ-036 The top level holds only the registers and the tc decode.
REQ-037 Elaboration fails if MODULUS < 2 or RESET_VAL >= MODULUS.

Verification (MODULUS=12 unless stated)
REQ-038 Reset, en=1, mode=1, wrap_en=1 for 13 clocks -> count 1..11, then 0 with carry_out=1 on that cycle only; tc=1 while count=11.
REQ-039 load 5 with mode=0, en=1, wrap_en=1 -> 5,4,3,2,1,0,11; borrow_out=1 with 11; tc=1 at 0.
REQ-040 load 10 (4'b1010), then up with wrap_en=0 -> 10,11,11,11; no carry_out.
REQ-041 load 14 (>=12) -> count_out=11, load_err=1 one cycle; load=1 and en=1 together -> load wins.
REQ-042 Drop reset_n between clock edges at count=7 -> count_out=0 immediately, all pulses 0; counting resumes from 0 after release.
REQ-043 MODULUS=16, WIDTH=4, up with wrap -> 15 wraps to 0 with carry_out; MODULUS=5 down from 0 -> 4 with borrow_out.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared constants for the modulo-N up/down counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package modn_pkg;

  // Direction encoding on the mode input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DN   = 1'b0;

  // Boundary policy encoding on the wrap_en input.
  localparam logic POL_WRAP = 1'b1;
  localparam logic POL_SAT  = 1'b0;

endpackage : modn_pkg

// File: rtl/modn_next.sv
// Next-count and event-flag decode for the modulo-N counter.
// Latency: purely combinational.
// Backpressure: none; the caller registers the results every edge.
module modn_next
  import modn_pkg::*;
#(
  parameter int MODULUS = 12,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_count,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  // One extra bit so MODULUS-1 and count+1 are exact even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0] CNT_MAX = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] din_x;
  logic [WIDTH:0] inc_x;

  assign cnt_x = {1'b0, count};
  assign din_x = {1'b0, data_in};
  assign inc_x = cnt_x + (WIDTH+1)'(1);

  // Priority load > en > hold; out-of-range loads clamp to the top value.
  always_comb begin
    next_count = count;
    carry      = 1'b0;
    borrow     = 1'b0;
    load_err   = 1'b0;
    if (load) begin
      if (din_x > CNT_MAX) begin
        next_count = CNT_MAX[WIDTH-1:0];
        load_err   = 1'b1;
      end else begin
        next_count = data_in;
      end
    end else if (en) begin
      if (mode == DIR_UP) begin
        if (inc_x <= CNT_MAX) begin
          next_count = inc_x[WIDTH-1:0];
        end else if (wrap_en == POL_WRAP) begin
          next_count = '0;
          carry      = 1'b1;
        end
      end else begin
        if (cnt_x != '0) begin
          next_count = count - 1'b1;
        end else if (wrap_en == POL_WRAP) begin
          next_count = CNT_MAX[WIDTH-1:0];
          borrow     = 1'b1;
        end
      end
    end
  end

endmodule : modn_next

// File: rtl/modn_updn_counter.sv
// Modulo-N up/down counter with load, wrap/saturate policy and event pulses.
// Latency: one clock from sampled inputs to count_out and pulses; tc is combinational.
// Backpressure: none; acts on every enabled clock edge.
module modn_updn_counter
  import modn_pkg::*;
#(
  parameter int MODULUS   = 12,
  parameter int WIDTH     = $clog2(MODULUS),
  parameter int RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             load_err
);

  if (MODULUS < 2) begin : g_bad_modulus
    $fatal(1, "modn_updn_counter: MODULUS must be at least 2");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $fatal(1, "modn_updn_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] next_count;
  logic             carry_nxt;
  logic             borrow_nxt;
  logic             load_err_nxt;

  modn_next #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_next (
    .count      (count_out),
    .load       (load),
    .en         (en),
    .mode       (mode),
    .wrap_en    (wrap_en),
    .data_in    (data_in),
    .next_count (next_count),
    .carry      (carry_nxt),
    .borrow     (borrow_nxt),
    .load_err   (load_err_nxt)
  );

  // Count and event pulses register together so pulses line up with the new count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_out  <= CNT_RST;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      count_out  <= next_count;
      carry_out  <= carry_nxt;
      borrow_out <= borrow_nxt;
      load_err   <= load_err_nxt;
    end
  end

  // Terminal count follows the current direction with no pipeline.
  assign tc = (mode == DIR_UP) ? (count_out == CNT_MAX) : (count_out == '0);

endmodule : modn_updn_counter

// File: tb/tb_modn_updn_counter.sv
// Directed bench driving three counter instances (MODULUS 12, 16, 5) with shared stimulus.
// Expected states come from a behavioural model queued at drive time, popped after the edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_modn_updn_counter;

  typedef struct {
    int   cnt;
    logic c;
    logic b;
    logic e;
  } st_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en, load, mode, wrap_en;
  logic [3:0] data_in;

  logic [3:0] c12, c16;
  logic [2:0] c5;
  logic       tc12, tc16, tc5;
  logic       cy12, cy16, cy5;
  logic       bo12, bo16, bo5;
  logic       le12, le16, le5;

  int tests = 0;
  int fails = 0;

  st_t st12, st16, st5;
  st_t q12[$], q16[$], q5[$];

  always #5 clock = ~clock;

  modn_updn_counter #(.MODULUS(12)) dut12 (
    .clock(clock), .reset_n(reset_n), .en(en), .load(load), .mode(mode),
    .wrap_en(wrap_en), .data_in(data_in), .count_out(c12), .tc(tc12),
    .carry_out(cy12), .borrow_out(bo12), .load_err(le12)
  );

  modn_updn_counter #(.MODULUS(16), .WIDTH(4)) dut16 (
    .clock(clock), .reset_n(reset_n), .en(en), .load(load), .mode(mode),
    .wrap_en(wrap_en), .data_in(data_in), .count_out(c16), .tc(tc16),
    .carry_out(cy16), .borrow_out(bo16), .load_err(le16)
  );

  modn_updn_counter #(.MODULUS(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .en(en), .load(load), .mode(mode),
    .wrap_en(wrap_en), .data_in(data_in[2:0]), .count_out(c5), .tc(tc5),
    .carry_out(cy5), .borrow_out(bo5), .load_err(le5)
  );

  // Reference behaviour of one counter for one clock edge.
  function automatic st_t model(input int m, input st_t s, input logic ld, input logic e,
                                input logic md, input logic wr, input logic [3:0] d);
    st_t n;
    int  dv;
    n.cnt = s.cnt;
    n.c   = 1'b0;
    n.b   = 1'b0;
    n.e   = 1'b0;
    dv = (m == 5) ? int'(d[2:0]) : int'(d);
    if (ld) begin
      if (dv >= m) begin
        n.cnt = m - 1;
        n.e   = 1'b1;
      end else begin
        n.cnt = dv;
      end
    end else if (e) begin
      if (md) begin
        if (s.cnt == m - 1) begin
          if (wr) begin n.cnt = 0; n.c = 1'b1; end
        end else begin
          n.cnt = s.cnt + 1;
        end
      end else begin
        if (s.cnt == 0) begin
          if (wr) begin n.cnt = m - 1; n.b = 1'b1; end
        end else begin
          n.cnt = s.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input integer obs, input integer exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string name, input int m, input st_t x, input integer cnt,
                         input logic cy, input logic bo, input logic le, input logic tcv);
    int tce;
    tce = mode ? int'(x.cnt == m - 1) : int'(x.cnt == 0);
    chk({name, " count"},    cnt,          x.cnt);
    chk({name, " carry"},    integer'(cy), integer'(x.c));
    chk({name, " borrow"},   integer'(bo), integer'(x.b));
    chk({name, " load_err"}, integer'(le), integer'(x.e));
    chk({name, " tc"},       integer'(tcv), tce);
  endtask

  // Drive one cycle of stimulus (also releases reset), queue expectations, check after the edge.
  task automatic step(input logic ld, input logic e, input logic md, input logic wr,
                      input logic [3:0] d);
    st_t x;
    @(negedge clock);
    load = ld; en = e; mode = md; wrap_en = wr; data_in = d;
    reset_n = 1'b1;
    st12 = model(12, st12, ld, e, md, wr, d); q12.push_back(st12);
    st16 = model(16, st16, ld, e, md, wr, d); q16.push_back(st16);
    st5  = model(5,  st5,  ld, e, md, wr, d); q5.push_back(st5);
    @(posedge clock);
    #1;
    x = q12.pop_front(); chk_dut("m12", 12, x, integer'(c12), cy12, bo12, le12, tc12);
    x = q16.pop_front(); chk_dut("m16", 16, x, integer'(c16), cy16, bo16, le16, tc16);
    x = q5.pop_front();  chk_dut("m5",  5,  x, integer'(c5),  cy5,  bo5,  le5,  tc5);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " m12 count"}, integer'(c12), 0);
    chk({tag, " m16 count"}, integer'(c16), 0);
    chk({tag, " m5 count"},  integer'(c5),  0);
    chk({tag, " pulses"}, integer'({cy12, bo12, le12, cy16, bo16, le16, cy5, bo5, le5}), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0; load = 1'b0; mode = 1'b1; wrap_en = 1'b1; data_in = 4'd0;
    st12 = '{0, 1'b0, 1'b0, 1'b0};
    st16 = st12;
    st5  = st12;
    #3;
    chk_reset("reset");

    // Up with wrap for 13 clocks from reset: 1..11, 0 with carry, 1.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);

    // Load 5 then count down with wrap: 5,4,3,2,1,0,11 with borrow.
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);

    // Load 10 then up with saturation: 10,11,11,11 and no carry.
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Out-of-range load with en also high, then an in-range load beating en, then hold.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd14);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

    // Top value: up wraps to 0 with carry, then down from 0 wraps with borrow.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);

    // Mode flips on the edge it is sampled; down saturates at 0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Reset dropped between edges at count 7 while load and en are requested.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    #2;
    load = 1'b1; en = 1'b1; data_in = 4'd9;
    reset_n = 1'b0;
    #1;
    st12 = '{0, 1'b0, 1'b0, 1'b0};
    st16 = st12;
    st5  = st12;
    chk_reset("mid reset");
    @(posedge clock);
    #1;
    chk_reset("held reset");

    // Release and resume counting from 0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_modn_updn_counter
